// File: rtl/register_scoreboard.sv
// Register scoreboard between Decode and Read: tracks in-flight writes per
// architectural register and gates instruction issue on RAW/WAW hazards.
module register_scoreboard #(
  parameter int unsigned NUM_REGS   = 16,
  parameter int unsigned CNT_WIDTH  = 2,
  parameter int unsigned STAT_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         resetN,
  input  logic                         instValidIn,
  input  logic [$clog2(NUM_REGS)-1:0]  sourceReg1In,
  input  logic                         sourceReg1ValidIn,
  input  logic [$clog2(NUM_REGS)-1:0]  sourceReg2In,
  input  logic                         sourceReg2ValidIn,
  input  logic [$clog2(NUM_REGS)-1:0]  destRegIn,
  input  logic                         destRegValidIn,
  input  logic [$clog2(NUM_REGS)-1:0]  destRegisterSpecialIn,
  input  logic                         destRegisterSpecialValidIn,
  input  logic                         stallIn,
  input  logic                         flushIn,
  input  logic [$clog2(NUM_REGS)-1:0]  wbRegIn,
  input  logic                         wbRegValidIn,
  input  logic [$clog2(NUM_REGS)-1:0]  wbRegSpecialIn,
  input  logic                         wbRegSpecialValidIn,
  output logic                         canReadOut,
  output logic                         stallOut,
  output logic [NUM_REGS-1:0]          busyMaskOut,
  output logic                         errorOut,
  output logic [STAT_WIDTH-1:0]        stallCyclesOut
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [CNT_WIDTH-1:0] pendingCount [NUM_REGS];
  logic [CNT_WIDTH-1:0] nextCount    [NUM_REGS];
  logic [NUM_REGS-1:0]  incMask;
  logic [NUM_REGS-1:0]  decMask;
  logic [NUM_REGS-1:0]  nextBusy;
  logic                 underflow;
  logic                 hazard;
  logic                 fire;

  always_comb begin
    hazard = instValidIn && (
               (sourceReg1ValidIn && (pendingCount[sourceReg1In] != '0)) ||
               (sourceReg2ValidIn && (pendingCount[sourceReg2In] != '0)) ||
               (destRegValidIn && (pendingCount[destRegIn] == CNT_MAX)) ||
               (destRegisterSpecialValidIn &&
                (pendingCount[destRegisterSpecialIn] == CNT_MAX)));
    fire       = instValidIn && !stallIn && !hazard && !flushIn && resetN;
    canReadOut = fire;
    stallOut   = !resetN || (instValidIn && (stallIn || hazard || flushIn));
  end

  // Setting mask bits (rather than counting) collapses duplicate register
  // names on either side to a single increment/decrement.
  always_comb begin
    incMask = '0;
    decMask = '0;
    if (fire && destRegValidIn)             incMask[destRegIn]             = 1'b1;
    if (fire && destRegisterSpecialValidIn) incMask[destRegisterSpecialIn] = 1'b1;
    if (wbRegValidIn)                       decMask[wbRegIn]               = 1'b1;
    if (wbRegSpecialValidIn)                decMask[wbRegSpecialIn]        = 1'b1;
  end

  always_comb begin
    underflow = 1'b0;
    nextBusy  = '0;
    for (int unsigned r = 0; r < NUM_REGS; r++) begin
      nextCount[r] = pendingCount[r];
      if (incMask[r] && !decMask[r]) begin
        nextCount[r] = pendingCount[r] + CNT_WIDTH'(1);
      end else if (decMask[r] && !incMask[r]) begin
        if (pendingCount[r] == '0) underflow = 1'b1;
        else nextCount[r] = pendingCount[r] - CNT_WIDTH'(1);
      end
      nextBusy[r] = (nextCount[r] != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      for (int unsigned r = 0; r < NUM_REGS; r++) pendingCount[r] <= '0;
      busyMaskOut    <= '0;
      errorOut       <= 1'b0;
      stallCyclesOut <= '0;
    end else begin
      if (flushIn) begin
        for (int unsigned r = 0; r < NUM_REGS; r++) pendingCount[r] <= '0;
        busyMaskOut <= '0;
      end else begin
        for (int unsigned r = 0; r < NUM_REGS; r++) pendingCount[r] <= nextCount[r];
        busyMaskOut <= nextBusy;
        if (underflow) errorOut <= 1'b1;
      end
      if (hazard && !stallIn && (stallCyclesOut != '1))
        stallCyclesOut <= stallCyclesOut + STAT_WIDTH'(1);
    end
  end

endmodule
